// File: rtl/pll_phase_pkg.sv
// Shared state encoding, reset values and modular phase arithmetic for the PLL phase stepper.
// Combinational helpers only; no latency or flow control of its own.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SWITCH,
        CALC,
        ARM,
        HOLD,
        WAIT_LO,
        WAIT_HI
    } state_e;

    localparam logic       RST_PHASEUPDOWN = 1'b1;
    localparam logic       RST_PHASESTEP   = 1'b0;
    localparam logic       RST_CLKSWITCH   = 1'b0;
    localparam logic [7:0] RST_CUR_PHASE   = 8'd0;
    localparam logic       RST_CUR_SRC     = 1'b0;

    // Upward distance tgt - cur modulo steps; adding steps first keeps every intermediate non-negative.
    function automatic logic [8:0] mod_dist_up(input logic [7:0] tgt,
                                               input logic [7:0] cur,
                                               input logic [8:0] steps);
        logic [8:0] sum;
        sum = {1'b0, tgt} + steps - {1'b0, cur};
        if (sum >= steps) begin
            sum = sum - steps;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pll_phase_stepper_if.sv
// Command-side bus between the serial command processor (master) and the phase stepper (slave).
// updatepll is a single-cycle request; status lines are level signals.
interface pll_phase_stepper_if;
    logic       updatepll;
    logic       pll_clk_src;
    logic [7:0] pll_clk_phase;
    logic       busy;
    logic [7:0] cur_phase;
    logic       cur_src;
    logic       err;

    modport master (
        output updatepll, pll_clk_src, pll_clk_phase,
        input  busy, cur_phase, cur_src, err
    );

    modport slave (
        input  updatepll, pll_clk_src, pll_clk_phase,
        output busy, cur_phase, cur_src, err
    );
endinterface

// File: rtl/pll_scanclk_gen.sv
// Free-running scanclk divider with one-cycle rise and fall (sf) strobes.
// Strobes are registered: each appears in the first clk cycle scanclk holds its new level; never stalls.
module pll_scanclk_gen #(
    parameter int SCANCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic scanclk,
    output logic rise,
    output logic sf
);

    localparam int CW = $clog2(SCANCLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          scanclk_q, scanclk_d;
    logic          rise_q, rise_d;
    logic          sf_q, sf_d;
    logic          tick;

    assign tick = (cnt_q == CW'(SCANCLK_DIV - 1));

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CW'(1);
        scanclk_d = tick ? ~scanclk_q : scanclk_q;
        rise_d    = tick && !scanclk_q;
        sf_d      = tick && scanclk_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            scanclk_q <= 1'b0;
            rise_q    <= 1'b0;
            sf_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            scanclk_q <= scanclk_d;
            rise_q    <= rise_d;
            sf_q      <= sf_d;
        end
    end

    assign scanclk = scanclk_q;
    assign rise    = rise_q;
    assign sf      = sf_q;

endmodule

// File: rtl/pll_phase_stepper.sv
// Applies requested PLL input-clock source and phase: optional clkswitch pulse, then single phase steps along the shortest path.
// Request accepted one cycle after updatepll in IDLE; a request while busy sets a single pending flag (no queue).
module pll_phase_stepper
    import pll_phase_pkg::*;
#(
    parameter int         PHASE_STEPS   = 56,
    parameter int         SCANCLK_DIV   = 4,
    parameter int         CLKSWITCH_CYC = 4,
    parameter int         TIMEOUT_CYC   = 4096,
    parameter logic [2:0] COUNTER_SEL   = 3'b000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    pll_phase_stepper_if.slave        cmd,
    input  logic                      phasedone,
    output logic [2:0]                phasecounterselect,
    output logic                      phaseupdown,
    output logic                      phasestep,
    output logic                      scanclk,
    output logic                      clkswitch
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + CLKSWITCH_CYC + 1);

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             err_q, err_d;
    logic [7:0]       cur_phase_q, cur_phase_d;
    logic             cur_src_q, cur_src_d;
    logic             phaseupdown_q, phaseupdown_d;
    logic             phasestep_q, phasestep_d;
    logic             clkswitch_q, clkswitch_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       rise_cnt_q, rise_cnt_d;
    logic             pd_meta_q, pd_meta_d;
    logic             pd_sync_q, pd_sync_d;

    logic             sc_rise;
    logic             sc_fall;
    logic [8:0]       up_dist;

    pll_scanclk_gen #(
        .SCANCLK_DIV (SCANCLK_DIV)
    ) u_scanclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .scanclk (scanclk),
        .rise    (sc_rise),
        .sf      (sc_fall)
    );

    assign up_dist = mod_dist_up(cmd.pll_clk_phase, cur_phase_q, 9'(PHASE_STEPS));

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        err_d         = err_q;
        cur_phase_d   = cur_phase_q;
        cur_src_d     = cur_src_q;
        phaseupdown_d = phaseupdown_q;
        phasestep_d   = phasestep_q;
        tmr_d         = '0;
        rise_cnt_d    = rise_cnt_q;
        pd_meta_d     = phasedone;
        pd_sync_d     = pd_meta_q;

        if (cmd.updatepll && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd.updatepll || pending_q) begin
                    pending_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = (cmd.pll_clk_src != cur_src_q) ? SWITCH : CALC;
                end
            end
            SWITCH: begin
                if (tmr_q == TMR_W'(CLKSWITCH_CYC - 1)) begin
                    cur_src_d = cmd.pll_clk_src;
                    state_d   = CALC;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            CALC: begin
                if ({1'b0, cmd.pll_clk_phase} >= 9'(PHASE_STEPS)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cmd.pll_clk_phase == cur_phase_q) begin
                    state_d = IDLE;
                end else begin
                    phaseupdown_d = (up_dist <= 9'(PHASE_STEPS / 2));
                    state_d       = ARM;
                end
            end
            ARM: begin
                rise_cnt_d = 2'd0;
                if (sc_fall) begin
                    phasestep_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // Strobe stays up across two scanclk rising edges so the PLL samples it, then drops on a falling edge.
                if (sc_rise && (rise_cnt_q != 2'd2)) begin
                    rise_cnt_d = rise_cnt_q + 2'd1;
                end
                if (sc_fall && (rise_cnt_q == 2'd2)) begin
                    phasestep_d = 1'b0;
                    state_d     = WAIT_LO;
                end
            end
            WAIT_LO: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!pd_sync_q) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (pd_sync_q) begin
                    if (phaseupdown_q) begin
                        cur_phase_d = (cur_phase_q == 8'(PHASE_STEPS - 1)) ? 8'd0 : cur_phase_q + 8'd1;
                    end else begin
                        cur_phase_d = (cur_phase_q == 8'd0) ? 8'(PHASE_STEPS - 1) : cur_phase_q - 8'd1;
                    end
                    state_d = CALC;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        clkswitch_d = (state_d == SWITCH);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            err_q         <= 1'b0;
            cur_phase_q   <= RST_CUR_PHASE;
            cur_src_q     <= RST_CUR_SRC;
            phaseupdown_q <= RST_PHASEUPDOWN;
            phasestep_q   <= RST_PHASESTEP;
            clkswitch_q   <= RST_CLKSWITCH;
            tmr_q         <= '0;
            rise_cnt_q    <= 2'd0;
            pd_meta_q     <= 1'b1;
            pd_sync_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
            cur_phase_q   <= cur_phase_d;
            cur_src_q     <= cur_src_d;
            phaseupdown_q <= phaseupdown_d;
            phasestep_q   <= phasestep_d;
            clkswitch_q   <= clkswitch_d;
            tmr_q         <= tmr_d;
            rise_cnt_q    <= rise_cnt_d;
            pd_meta_q     <= pd_meta_d;
            pd_sync_q     <= pd_sync_d;
        end
    end

    assign phasecounterselect = COUNTER_SEL;
    assign phaseupdown        = phaseupdown_q;
    assign phasestep          = phasestep_q;
    assign clkswitch          = clkswitch_q;
    assign cmd.busy           = (state_q != IDLE);
    assign cmd.cur_phase      = cur_phase_q;
    assign cmd.cur_src        = cur_src_q;
    assign cmd.err            = err_q;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper with a behavioural PLL phasedone model.
module tb_pll_phase_stepper;

    logic       clk;
    logic       reset_n;
    logic       phasedone;
    logic [2:0] phasecounterselect;
    logic       phaseupdown;
    logic       phasestep;
    logic       scanclk;
    logic       clkswitch;
    logic       pd_stuck;

    pll_phase_stepper_if cmd_if();

    pll_phase_stepper dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cmd                (cmd_if),
        .phasedone          (phasedone),
        .phasecounterselect (phasecounterselect),
        .phaseupdown        (phaseupdown),
        .phasestep          (phasestep),
        .scanclk            (scanclk),
        .clkswitch          (clkswitch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PLL model: phasedone drops 3 scanclk edges after the 2nd rising edge seen with phasestep high, rises 5 edges later.
    logic       sc_prev = 1'b0;
    logic       ps_prev = 1'b0;
    logic       cs_prev = 1'b0;
    int         m_st = 0;
    int         m_cnt = 0;
    int         n_steps = 0;
    int         n_ups = 0;
    int         n_sw = 0;
    logic [7:0] cp_prev = 8'd0;
    logic [7:0] hist1 = 8'd0;
    logic [7:0] hist2 = 8'd0;

    always @(negedge clk) begin
        sc_prev <= scanclk;
        ps_prev <= phasestep;
        cs_prev <= clkswitch;
        if (phasestep && !ps_prev) begin
            n_steps <= n_steps + 1;
            if (phaseupdown) n_ups <= n_ups + 1;
        end
        if (clkswitch) n_sw <= n_sw + 1;
        if (cmd_if.cur_phase != cp_prev) begin
            cp_prev <= cmd_if.cur_phase;
            hist1   <= cmd_if.cur_phase;
            hist2   <= hist1;
        end
        if (!reset_n) begin
            m_st      <= 0;
            m_cnt     <= 0;
            phasedone <= 1'b1;
        end else if (scanclk != sc_prev) begin
            case (m_st)
                0: if (scanclk && phasestep) begin
                    if (m_cnt == 1) begin m_st <= 1; m_cnt <= 0; end
                    else m_cnt <= m_cnt + 1;
                end
                1: if (m_cnt == 2) begin
                    if (!pd_stuck) phasedone <= 1'b0;
                    m_st <= 2; m_cnt <= 0;
                end else m_cnt <= m_cnt + 1;
                default: if (m_cnt == 4) begin
                    phasedone <= 1'b1;
                    m_st <= 0; m_cnt <= 0;
                end else m_cnt <= m_cnt + 1;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic s, input logic [7:0] p, input string name);
        cmd_if.pll_clk_src   = s;
        cmd_if.pll_clk_phase = p;
        cmd_if.updatepll     = 1'b1;
        @(negedge clk);
        cmd_if.updatepll     = 1'b0;
        check(name, int'(cmd_if.busy), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (cmd_if.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(cmd_if.busy), 0);
    endtask

    task automatic wait_ps(input logic level, input int budget, input string name);
        int n = 0;
        while (phasestep !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(phasestep), int'(level));
    endtask

    typedef struct {
        logic       src;
        logic [7:0] phase;
        int         steps;
        int         ups;
        int         sw;
        int         cur;
        int         csrc;
        int         err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation limit reached, busy=%0d", cmd_if.busy);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, u0, w0, n;

        vecs[0] = '{src: 1'b0, phase: 8'd3,  steps: 3,  ups: 3,  sw: 0, cur: 3,  csrc: 0, err: 0};
        vecs[1] = '{src: 1'b0, phase: 8'd0,  steps: 3,  ups: 0,  sw: 0, cur: 0,  csrc: 0, err: 0};
        vecs[2] = '{src: 1'b0, phase: 8'd28, steps: 28, ups: 28, sw: 0, cur: 28, csrc: 0, err: 0};
        vecs[3] = '{src: 1'b0, phase: 8'd0,  steps: 28, ups: 28, sw: 0, cur: 0,  csrc: 0, err: 0};
        vecs[4] = '{src: 1'b0, phase: 8'd55, steps: 1,  ups: 0,  sw: 0, cur: 55, csrc: 0, err: 0};
        vecs[5] = '{src: 1'b1, phase: 8'd55, steps: 0,  ups: 0,  sw: 4, cur: 55, csrc: 1, err: 0};
        vecs[6] = '{src: 1'b0, phase: 8'd1,  steps: 2,  ups: 2,  sw: 4, cur: 1,  csrc: 0, err: 0};
        vecs[7] = '{src: 1'b0, phase: 8'd60, steps: 0,  ups: 0,  sw: 0, cur: 1,  csrc: 0, err: 1};
        vecs[8] = '{src: 1'b0, phase: 8'd1,  steps: 0,  ups: 0,  sw: 0, cur: 1,  csrc: 0, err: 0};

        reset_n              = 1'b0;
        pd_stuck             = 1'b0;
        cmd_if.updatepll     = 1'b0;
        cmd_if.pll_clk_src   = 1'b0;
        cmd_if.pll_clk_phase = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(cmd_if.busy), 0);
        check("rst_scanclk", int'(scanclk), 0);
        check("rst_phaseupdown", int'(phaseupdown), 1);
        check("rst_pcs", int'(phasecounterselect), 0);
        check("rst_cur_phase", int'(cmd_if.cur_phase), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            s0 = n_steps; u0 = n_ups; w0 = n_sw;
            issue(vecs[i].src, vecs[i].phase, $sformatf("v%0d_accept", i));
            wait_idle(5000, $sformatf("v%0d_idle", i));
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_steps", i), n_steps - s0, vecs[i].steps);
            check($sformatf("v%0d_ups", i), n_ups - u0, vecs[i].ups);
            check($sformatf("v%0d_swcyc", i), n_sw - w0, vecs[i].sw);
            check($sformatf("v%0d_cur_phase", i), int'(cmd_if.cur_phase), vecs[i].cur);
            check($sformatf("v%0d_cur_src", i), int'(cmd_if.cur_src), vecs[i].csrc);
            check($sformatf("v%0d_err", i), int'(cmd_if.err), vecs[i].err);
        end

        // phasedone never falls: WAIT_LO times out after TIMEOUT_CYC cycles
        pd_stuck = 1'b1;
        s0 = n_steps;
        issue(1'b0, 8'd2, "to_accept");
        wait_ps(1'b1, 200, "to_ps_hi");
        wait_ps(1'b0, 200, "to_ps_lo");
        n = 0;
        while (cmd_if.busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", n, 4096);
        check("to_err", int'(cmd_if.err), 1);
        check("to_cur_phase", int'(cmd_if.cur_phase), 1);
        check("to_steps", n_steps - s0, 1);
        pd_stuck = 1'b0;
        repeat (100) @(negedge clk);

        // New request during the first step of 0->3, with target moved to 1
        issue(1'b0, 8'd0, "pend_pre_accept");
        wait_idle(5000, "pend_pre_idle");
        check("pend_pre_err", int'(cmd_if.err), 0);
        check("pend_pre_cur", int'(cmd_if.cur_phase), 0);
        s0 = n_steps;
        issue(1'b0, 8'd3, "pend_accept");
        wait_ps(1'b1, 200, "pend_ps_hi");
        cmd_if.pll_clk_phase = 8'd1;
        cmd_if.updatepll     = 1'b1;
        @(negedge clk);
        cmd_if.updatepll     = 1'b0;
        wait_idle(5000, "pend_idle");
        repeat (10) @(negedge clk);
        check("pend_busy", int'(cmd_if.busy), 0);
        check("pend_cur", int'(cmd_if.cur_phase), 1);
        check("pend_steps", n_steps - s0, 1);

        // 0 -> 54 goes down through the wrap: 55 then 54
        issue(1'b0, 8'd0, "dn_pre_accept");
        wait_idle(5000, "dn_pre_idle");
        s0 = n_steps; u0 = n_ups;
        issue(1'b0, 8'd54, "dn_accept");
        wait_idle(5000, "dn_idle");
        repeat (2) @(negedge clk);
        check("dn_steps", n_steps - s0, 2);
        check("dn_ups", n_ups - u0, 0);
        check("dn_dir", int'(phaseupdown), 0);
        check("dn_hist_first", int'(hist2), 55);
        check("dn_hist_last", int'(hist1), 54);

        // Reset in the middle of a step with a request pending
        issue(1'b1, 8'd50, "rs_accept");
        wait_ps(1'b1, 300, "rs_ps_hi");
        cmd_if.updatepll = 1'b1;
        @(negedge clk);
        cmd_if.updatepll = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("rs_phasestep", int'(phasestep), 0);
        check("rs_scanclk", int'(scanclk), 0);
        check("rs_busy", int'(cmd_if.busy), 0);
        check("rs_clkswitch", int'(clkswitch), 0);
        check("rs_phaseupdown", int'(phaseupdown), 1);
        check("rs_cur_phase", int'(cmd_if.cur_phase), 0);
        check("rs_cur_src", int'(cmd_if.cur_src), 0);
        check("rs_err", int'(cmd_if.err), 0);
        check("rs_pcs", int'(phasecounterselect), 0);
        @(negedge clk);
        reset_n = 1'b1;
        s0 = n_steps;
        repeat (60) @(negedge clk);
        check("rs_post_busy", int'(cmd_if.busy), 0);
        check("rs_post_steps", n_steps - s0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
